// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one register-to-register ALU operation per start pulse over an 8x16 register file
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [2:0]  rd,
    input  logic        wb,
    input  logic        ext_we,
    input  logic [2:0]  ext_addr,
    input  logic [15:0] ext_data,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] result
);
    typedef enum logic [2:0] {IDLE, LOADA, LOADB, EXEC, WRITE} state_t;
    state_t state, state_nx;
    logic [15:0] regs [8];
    logic [15:0] a, b, c, alu_out, sum, diff;
    logic [2:0]  alu_st, status_q, rn_q, rm_q, rd_q;
    logic [1:0]  op_q;
    logic        wb_q, alu_v, we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // fixed walk IDLE -> LOADA -> LOADB -> EXEC -> WRITE -> IDLE; only IDLE waits on start
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOADA : IDLE;
            LOADA:   state_nx = LOADB;
            LOADB:   state_nx = EXEC;
            EXEC:    state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
    end
    // capture the request fields so the host may change them while we run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rn_q <= '0;
            rm_q <= '0;
            rd_q <= '0;
            wb_q <= 1'b0;
        end else if (state == IDLE && start) begin
            op_q <= op;
            rn_q <= rn;
            rm_q <= rm;
            rd_q <= rd;
            wb_q <= wb;
        end
    end
    // combinational ALU: add/sub/and/not-B with {V,N,Z}; V only meaningful for arithmetic
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_out = op_q == 2'b00 ? sum :
                  op_q == 2'b01 ? diff :
                  op_q == 2'b10 ? (a & b) : ~b;
        alu_v   = op_q == 2'b00 ? (a[15] == b[15]) && (sum[15] != a[15]) :
                  op_q == 2'b01 ? (a[15] != b[15]) && (diff[15] != a[15]) : 1'b0;
        alu_st  = {alu_v, alu_out[15], alu_out == 16'h0000};
    end
    // operand fetch, execute and status latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            c        <= '0;
            status_q <= '0;
        end else begin
            if (state == LOADA) a <= regs[rn_q];
            if (state == LOADB) b <= regs[rm_q];
            if (state == EXEC) begin
                c        <= alu_out;
                status_q <= alu_st;
            end
        end
    end
    // single write port shared by host loads (IDLE only) and write-back (WRITE only)
    always_comb begin
        we    = (state == IDLE && ext_we) || (state == WRITE && wb_q);
        waddr = state == IDLE ? ext_addr : rd_q;
        wdata = state == IDLE ? ext_data : c;
    end
    // register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end
    assign dbg_data = regs[dbg_addr];
    assign busy     = state != IDLE;
    assign done     = state == WRITE;
    assign status   = status_q;
    assign result   = c;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer using directed operations
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, wb, ext_we;
    logic [1:0]  op;
    logic [2:0]  rn, rm, rd, ext_addr, dbg_addr;
    logic [15:0] ext_data, dbg_data, result;
    logic        busy, done;
    logic [2:0]  status;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  st;
    } exp_t;
    exp_t sb[$];

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rn(rn), .rm(rm), .rd(rd),
        .wb(wb), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done),
        .status(status), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no operation pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("status", {13'b0, status}, {13'b0, e.st});
            end
        end
    end

    task automatic ext_load(input logic [2:0] a, input logic [15:0] d);
        ext_addr = a;
        ext_data = d;
        ext_we   = 1'b1;
        @(negedge clk);
        ext_we   = 1'b0;
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [15:0] e, input string name);
        dbg_addr = a;
        #1;
        check(name, dbg_data, e);
    endtask

    // issue one op from an IDLE negedge; noise drives start/ext_we during the first busy cycles
    task automatic run(input logic [1:0] o, input logic [2:0] n_, input logic [2:0] m_,
                       input logic [2:0] d_, input logic w, input logic [15:0] res,
                       input logic [2:0] st, input bit noise);
        int  n = 0;
        bit  seen = 0;
        exp_t e;
        e.res = res;
        e.st  = st;
        sb.push_back(e);
        op = o; rn = n_; rm = m_; rd = d_; wb = w;
        start = 1'b1;
        while (n < 10 && !seen) begin
            @(negedge clk);
            n++;
            start  = noise && n <= 2;
            ext_we = noise && n <= 2;
            if (noise) begin
                ext_addr = 3'd1;
                ext_data = 16'hAAAA;
            end
            if (n == 1) check("busy_during_op", {15'b0, busy}, 16'h0001);
            if (done) seen = 1;
        end
        start  = 1'b0;
        ext_we = 1'b0;
        check("done_latency", 16'(n), 16'd4);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; rn = '0; rm = '0; rd = '0; wb = 1'b0;
        ext_we = 1'b0; ext_addr = '0; ext_data = '0; dbg_addr = '0;
        @(negedge clk);
        check("reset_busy", {15'b0, busy}, 16'h0000);
        check("reset_done", {15'b0, done}, 16'h0000);
        check("reset_status", {13'b0, status}, 16'h0000);
        chk_reg(3'd3, 16'h0000, "reset_r3");
        rst_n = 1'b1;
        @(negedge clk);
        ext_load(3'd1, 16'h7FFF);
        ext_load(3'd2, 16'h0001);
        ext_load(3'd4, 16'h5555);
        chk_reg(3'd1, 16'h7FFF, "ext_load_r1");
        // add with signed overflow
        run(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 16'h8000, 3'b110, 0);
        chk_reg(3'd3, 16'h8000, "add_r3");
        // zero result
        run(2'b01, 3'd1, 3'd1, 3'd4, 1'b1, 16'h0000, 3'b001, 0);
        chk_reg(3'd4, 16'h0000, "sub_zero_r4");
        // not-B overwriting its own source
        run(2'b11, 3'd0, 3'd2, 3'd2, 1'b1, 16'hFFFE, 3'b010, 0);
        chk_reg(3'd2, 16'hFFFE, "notb_r2");
        // compare-only leaves the register file alone
        ext_load(3'd5, 16'h1234);
        ext_load(3'd6, 16'h1234);
        run(2'b01, 3'd5, 3'd6, 3'd5, 1'b0, 16'h0000, 3'b001, 0);
        chk_reg(3'd5, 16'h1234, "cmp_r5_kept");
        // and
        run(2'b10, 3'd1, 3'd2, 3'd7, 1'b1, 16'h7FFE, 3'b000, 0);
        chk_reg(3'd7, 16'h7FFE, "and_r7");
        // start and ext_we while busy must be ignored
        run(2'b00, 3'd1, 3'd1, 3'd6, 1'b1, 16'hFFFE, 3'b110, 1);
        repeat (4) @(negedge clk);
        chk_reg(3'd1, 16'h7FFF, "busy_ext_ignored_r1");
        chk_reg(3'd6, 16'hFFFE, "busy_add_r6");
        check("busy_idle_after", {15'b0, busy}, 16'h0000);
        // same-cycle ext_we and start in IDLE: operand sees the new value
        ext_addr = 3'd1;
        ext_data = 16'h0003;
        ext_we   = 1'b1;
        run(2'b00, 3'd1, 3'd0, 3'd7, 1'b1, 16'h0003, 3'b000, 0);
        chk_reg(3'd1, 16'h0003, "same_cycle_r1");
        chk_reg(3'd7, 16'h0003, "same_cycle_r7");
        // back-to-back: each op reads the previous write-back
        run(2'b00, 3'd7, 3'd7, 3'd7, 1'b1, 16'h0006, 3'b000, 0);
        run(2'b00, 3'd7, 3'd7, 3'd0, 1'b1, 16'h000C, 3'b000, 0);
        chk_reg(3'd0, 16'h000C, "b2b_r0");
        // subtract with signed overflow
        run(2'b01, 3'd0, 3'd3, 3'd1, 1'b1, 16'h800C, 3'b110, 0);
        chk_reg(3'd1, 16'h800C, "sub_ovf_r1");
        // reset asserted in EXEC
        op = 2'b00; rn = 3'd7; rm = 3'd7; rd = 3'd3; wb = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {15'b0, busy}, 16'h0000);
        check("rst_done", {15'b0, done}, 16'h0000);
        check("rst_status", {13'b0, status}, 16'h0000);
        check("rst_result", result, 16'h0000);
        for (int i = 0; i < 8; i++) chk_reg(3'(i), 16'h0000, $sformatf("rst_r%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_reg(3'd3, 16'h0000, "rst_no_writeback_r3");
        check("rst_idle_busy", {15'b0, busy}, 16'h0000);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
